// File: rtl/jpeg_pipeline_ctrl.sv
// jpeg_pipeline_ctrl: block sequencer for the RGB->YCbCr / 3x DCT / quantize / zigzag pipeline.
// It accepts RGB blocks, waits out the colour-conversion latency, and issues each block to the
// three DCT channels under per-channel handshakes. It then joins the DCT outputs, tracks the
// blocks in flight and emits a tagged result strobe after the quantize/zigzag latency.
// Optional feature macro: JPEG_CTRL_PERF_EN adds saturating 32-bit performance counters.
module jpeg_pipeline_ctrl #(
    parameter int PRE_LAT      = 1,
    parameter int POST_LAT     = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int TAG_W        = 8,
    parameter int SKEW_MAX     = 3
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             src_valid,
    output logic                             src_ready,
    output logic                             src_busy,
    output logic [2:0]                       dct_in_valid,
    input  logic [2:0]                       dct_in_ready,
    input  logic [2:0]                       dct_out_valid,
    output logic [2:0]                       dct_out_ready,
    input  logic                             dst_stall,
    output logic                             dst_valid,
    output logic [TAG_W-1:0]                 dst_tag,
    output logic [$clog2(MAX_INFLIGHT):0]    inflight,
    output logic                             err_desync
`ifdef JPEG_CTRL_PERF_EN
    ,
    output logic [31:0]                      perf_blocks,
    output logic [31:0]                      perf_stall,
    output logic [31:0]                      perf_issue_wait
`endif
);

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int SW = $clog2(SKEW_MAX + 2);
    localparam logic [3:0] PRE_LOAD = (PRE_LAT > 0) ? 4'(PRE_LAT - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_ISSUE} state_t;

    state_t                          state_q, state_d;
    logic [3:0]                      pre_cnt_q, pre_cnt_d;
    logic [2:0]                      acc_mask_q, acc_mask_d;
    logic [TAG_W-1:0]                tag_cnt_q, tag_cnt_d;
    logic [CW-1:0]                   inflight_q, inflight_d;
    logic [PW-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]                   skew_q, skew_d;
    logic                            err_q, err_d;
    logic [POST_LAT-1:0]             dl_valid_q, dl_valid_d;
    logic [POST_LAT-1:0][TAG_W-1:0]  dl_tag_q, dl_tag_d;
    logic [TAG_W-1:0]                fifo_mem [MAX_INFLIGHT];
    logic                            push, join_now, fifo_empty, partial;

    assign fifo_empty    = (inflight_q == '0);
    assign join_now      = (&dct_out_valid) & ~fifo_empty & ~dst_stall;
    assign partial       = (|dct_out_valid) & ~(&dct_out_valid);
    assign dct_out_ready = {3{join_now}};
    assign src_busy      = (state_q != ST_IDLE);
    assign dst_valid     = dl_valid_q[POST_LAT-1];
    assign dst_tag       = dl_tag_q[POST_LAT-1];
    assign inflight      = inflight_q;
    assign err_desync    = err_q;

    // Input FSM: accept a block, wait the conversion latency, then issue to the three channels.
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        acc_mask_d   = acc_mask_q;
        tag_cnt_d    = tag_cnt_q;
        src_ready    = 1'b0;
        dct_in_valid = 3'b000;
        push         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                src_ready = (inflight_q < CW'(MAX_INFLIGHT));
                if (src_valid && src_ready) begin
                    push       = 1'b1;
                    tag_cnt_d  = tag_cnt_q + 1'b1;
                    acc_mask_d = 3'b000;
                    pre_cnt_d  = PRE_LOAD;
                    state_d    = (PRE_LAT == 0) ? ST_ISSUE : ST_PRE;
                end
            end
            ST_PRE: begin
                if (pre_cnt_q == 4'd0) state_d = ST_ISSUE;
                else                   pre_cnt_d = pre_cnt_q - 1'b1;
            end
            ST_ISSUE: begin
                dct_in_valid = ~acc_mask_q;
                acc_mask_d   = acc_mask_q | (dct_in_valid & dct_in_ready);
                if (&acc_mask_d) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tag FIFO pointers, in-flight count, result delay line and desync detection.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = join_now ? rd_ptr_q + 1'b1 : rd_ptr_q;
        inflight_d = inflight_q;
        case ({push, join_now})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
        dl_valid_d    = dl_valid_q;
        dl_tag_d      = dl_tag_q;
        dl_valid_d[0] = join_now;
        dl_tag_d[0]   = join_now ? fifo_mem[rd_ptr_q] : '0;
        for (int i = 1; i < POST_LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_tag_d[i]   = dl_tag_q[i-1];
        end
        // Skew counter saturates at SKEW_MAX; one more partial cycle beyond that is an error.
        skew_d = '0;
        if (partial) skew_d = (skew_q == SW'(SKEW_MAX)) ? skew_q : skew_q + 1'b1;
        err_d = err_q | (partial && (skew_q == SW'(SKEW_MAX))) | ((|dct_out_valid) && fifo_empty);
    end

    // Tag storage; stale entries after reset are unreachable because the pointers restart.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= tag_cnt_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pre_cnt_q  <= '0;
            acc_mask_q <= '0;
            tag_cnt_q  <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            skew_q     <= '0;
            err_q      <= 1'b0;
            dl_valid_q <= '0;
            dl_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            acc_mask_q <= acc_mask_d;
            tag_cnt_q  <= tag_cnt_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            skew_q     <= skew_d;
            err_q      <= err_d;
            dl_valid_q <= dl_valid_d;
            dl_tag_q   <= dl_tag_d;
        end
    end

`ifdef JPEG_CTRL_PERF_EN
    logic [31:0] perf_blocks_q, perf_blocks_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_issue_wait_q, perf_issue_wait_d;

    // Saturating event counters.
    always_comb begin
        perf_blocks_d     = perf_blocks_q;
        perf_stall_d      = perf_stall_q;
        perf_issue_wait_d = perf_issue_wait_q;
        if (dst_valid && (perf_blocks_q != '1))
            perf_blocks_d = perf_blocks_q + 32'd1;
        if (dst_stall && (&dct_out_valid) && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 32'd1;
        if ((state_q == ST_ISSUE) && (|(dct_in_valid & ~dct_in_ready)) && (perf_issue_wait_q != '1))
            perf_issue_wait_d = perf_issue_wait_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_blocks_q     <= '0;
            perf_stall_q      <= '0;
            perf_issue_wait_q <= '0;
        end else begin
            perf_blocks_q     <= perf_blocks_d;
            perf_stall_q      <= perf_stall_d;
            perf_issue_wait_q <= perf_issue_wait_d;
        end
    end

    assign perf_blocks     = perf_blocks_q;
    assign perf_stall      = perf_stall_q;
    assign perf_issue_wait = perf_issue_wait_q;
`endif

endmodule
